pw_verify_ctrl: RTL and testbench
=================================

# pw_verify_ctrl

Door-lock decision stage downstream of the keypad entry/display stage. Captures each completed 4-digit BCD code, compares it with the stored password, and drives the door-unlock and alarm outputs. It counts failed attempts and enforces a timed lockout. During open and lockout periods it supplies the seconds countdown (`enb_count`, `led_cnt16`) back to the display stage, and pulses `clear_entry` so the entry stage restarts.

## Interface
- `DEFAULT_PW`, 16'h1234, password loaded at reset; four BCD digits, MS digit first.
- `MAX_FAIL`, 3, consecutive mismatches that trigger lockout; range 1..3.
- `OPEN_SEC`, 5, unlock duration in seconds; range 1..99.
- `LOCKOUT_SEC`, 30, lockout duration in seconds; range 1..99.
- `TICKS_PER_SEC`, 12500, clock cycles per second; range 2..16383.

Ports:
- `clk_12500hz` in 1: clock, all logic on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `enough` in 1: entry-complete level from the entry stage; stays high until that stage is cleared.
- `pw_16bit` in 16: entered code, valid while `enough`=1.
- `set_mode` in 1: level; while in OPEN, a new entry becomes the stored password.
- `unlock` out 1: door-release drive.
- `alarm` out 1: high during lockout.
- `enb_count` out 1: display shows `led_cnt16` when this is high.
- `led_cnt16` out 16: countdown digits {F,F,tens,ones}; 4'hF means blank.
- `clear_entry` out 1: one-cycle pulse that resets the entry stage (ORed into its reset at top level).
- `fail_cnt` out 2: current consecutive-failure count.

## Operation
- States: IDLE, CHECK, OPEN, LOCKOUT.
- Attempt edge: `enough`=1 and `enough_d`=0. `enough_d` resets to 1, so a level that is already high when reset releases is not treated as an attempt.
- IDLE:
  - On an attempt edge, latch `pw_16bit` into `cap` and go to CHECK.
- CHECK (exactly 1 cycle). The code matches only if `cap`==stored and every nibble of `cap` is ≤9.
  - Match: go to OPEN; `fail_cnt`←0; load seconds←`OPEN_SEC`; tick←0; pulse `clear_entry`.
  - Mismatch with `fail_cnt`+1 == `MAX_FAIL`: go to LOCKOUT; `fail_cnt`←0; load `LOCKOUT_SEC`; pulse `clear_entry`.
  - Other mismatch: `fail_cnt`+1; go to IDLE; pulse `clear_entry`.
- OPEN:
  - `unlock`=1, `enb_count`=1.
  - Attempt edge with `set_mode`=1 and all nibbles ≤9: stored←`pw_16bit`; pulse `clear_entry`; go to IDLE (relock).
  - Attempt edge otherwise: ignored except that `clear_entry` pulses.
  - On timer expiry: go to IDLE and pulse `clear_entry`.
- LOCKOUT:
  - `alarm`=1, `enb_count`=1.
  - Attempt edges are not compared; each one only pulses `clear_entry`.
  - On timer expiry: go to IDLE and pulse `clear_entry`.
- Countdown:
  - Tick counter is 14 bits and counts 0..`TICKS_PER_SEC`-1.
  - On wrap, the two-digit BCD seconds value decrements: ones 0→9 with a tens borrow.
  - Expiry is the wrap that occurs while seconds==01. Seconds never displays 00.
- `led_cnt16`:
  - {4'hF, 4'hF, tens, ones}; tens is shown as 4'hF when it is 0.
  - 16'hFFFF in IDLE and CHECK.
- Simultaneous events: in OPEN, expiry and an attempt edge in the same cycle → expiry wins, the entry is discarded, and a single `clear_entry` pulse is issued.
- Reset mid-operation:
  - State←IDLE; stored←`DEFAULT_PW`; `cap`←0.
  - All outputs go to their reset values immediately (asynchronously).

## Timing
- Reset values: `unlock`=0, `alarm`=0, `enb_count`=0, `led_cnt16`=16'hFFFF, `clear_entry`=0, `fail_cnt`=0.
- All outputs are registered.
- Attempt edge sampled at clock edge k:
  - CHECK is active after edge k.
  - `unlock`/`alarm`/`fail_cnt`/`clear_entry` update after edge k+1.
  - `clear_entry` is high for exactly one cycle.
- OPEN holds `unlock` for exactly `OPEN_SEC`×`TICKS_PER_SEC` cycles. LOCKOUT holds `alarm` for exactly `LOCKOUT_SEC`×`TICKS_PER_SEC` cycles.
- `enb_count` and the first countdown value (e.g. 05) appear in the same cycle as `unlock` or `alarm`.
- Minimum spacing between accepted attempts is 2 cycles. An edge arriving during CHECK is lost, and is impossible anyway because `enough` only rises after a clear.

## Test plan
Unless stated otherwise, all scenarios use `TICKS_PER_SEC`=4, `OPEN_SEC`=2, `LOCKOUT_SEC`=3.
- Reset, then enter 16'h1234 → `unlock`=1 two cycles after the edge; `led_cnt16`=FFF2 then FFF1; `unlock`=0 after exactly 8 cycles; one `clear_entry` pulse at entry and one at expiry.
- Enter 16'h1111 three times → `fail_cnt` goes 1, 2, then 0; `alarm`=1 with `led_cnt16`=FFF3; `alarm` held 12 cycles; 16'h1234 entered during lockout does not unlock.
- Unlock, then enter 16'h5678 with `set_mode`=1 → IDLE and `unlock`=0; 16'h1234 now fails; 16'h5678 unlocks.
- Enter 16'h12FF (blank digits), and in OPEN with `set_mode`=1 enter 16'hA234 → rejected as mismatch; stored password unchanged.
- Hold `enough`=1 through reset release → no attempt registered. Assert `reset` mid-OPEN after a password change → `unlock`=0 immediately and 16'h1234 accepted again.
- `LOCKOUT_SEC`=12, `TICKS_PER_SEC`=2 → `led_cnt16` sequence FF12, FF11, FF10, FFF9 … FFF1, then 16'hFFFF.

Source files
------------

// File: rtl/pw_verify_if.sv
// rtl/pw_verify_if.sv - entry-stage <-> password-verify signal bundle
interface pw_verify_if;
    logic        enough;
    logic [15:0] pw_16bit;
    logic        set_mode;
    logic        unlock;
    logic        alarm;
    logic        enb_count;
    logic [15:0] led_cnt16;
    logic        clear_entry;
    logic [1:0]  fail_cnt;

    modport master (
        output enough, pw_16bit, set_mode,
        input  unlock, alarm, enb_count, led_cnt16, clear_entry, fail_cnt
    );

    modport slave (
        input  enough, pw_16bit, set_mode,
        output unlock, alarm, enb_count, led_cnt16, clear_entry, fail_cnt
    );
endinterface

// File: rtl/pw_verify_ctrl.sv
// rtl/pw_verify_ctrl.sv - password compare, unlock/lockout timing and countdown for the door lock
module pw_verify_ctrl #(
    parameter logic [15:0] DEFAULT_PW    = 16'h1234,
    parameter int          MAX_FAIL      = 3,
    parameter int          OPEN_SEC      = 5,
    parameter int          LOCKOUT_SEC   = 30,
    parameter int          TICKS_PER_SEC = 12500
) (
    input  logic        clk_12500hz,
    input  logic        reset,
    pw_verify_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CHECK, OPEN, LOCKOUT} state_t;

    localparam logic [13:0] TICK_MAX   = 14'(TICKS_PER_SEC - 1);
    localparam logic [3:0]  OPEN_TENS  = 4'(OPEN_SEC / 10);
    localparam logic [3:0]  OPEN_ONES  = 4'(OPEN_SEC % 10);
    localparam logic [3:0]  LOCK_TENS  = 4'(LOCKOUT_SEC / 10);
    localparam logic [3:0]  LOCK_ONES  = 4'(LOCKOUT_SEC % 10);
    localparam logic [2:0]  FAIL_LIMIT = 3'(MAX_FAIL);

    function automatic logic bcd_ok(input logic [15:0] v);
        return (v[15:12] <= 4'd9) && (v[11:8] <= 4'd9) && (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    state_t      state, state_n;
    logic        enough_d;
    logic [15:0] cap, cap_n, stored, stored_n;
    logic [1:0]  fail_q, fail_n;
    logic [13:0] tick, tick_n;
    logic [3:0]  tens, tens_n, ones, ones_n, tens_show;
    logic        clear_n, timed_n;
    logic        unlock_q, alarm_q, enb_q, clear_q;
    logic [15:0] led_q;
    logic        attempt, wrap, expire, cap_ok;

    assign attempt   = bus.enough & ~enough_d;
    assign wrap      = (tick == TICK_MAX);
    assign expire    = wrap && (tens == 4'd0) && (ones == 4'd1);
    assign cap_ok    = (cap == stored) && bcd_ok(cap);
    assign timed_n   = (state_n == OPEN) || (state_n == LOCKOUT);
    assign tens_show = (tens_n == 4'd0) ? 4'hF : tens_n;

    always_comb begin
        state_n  = state;
        cap_n    = cap;
        stored_n = stored;
        fail_n   = fail_q;
        tick_n   = tick;
        tens_n   = tens;
        ones_n   = ones;
        clear_n  = 1'b0;
        case (state)
            IDLE: begin
                if (attempt) begin
                    cap_n   = bus.pw_16bit;
                    state_n = CHECK;
                end
            end
            CHECK: begin
                clear_n = 1'b1;
                tick_n  = '0;
                if (cap_ok) begin
                    state_n = OPEN;
                    fail_n  = 2'd0;
                    tens_n  = OPEN_TENS;
                    ones_n  = OPEN_ONES;
                end else if ({1'b0, fail_q} + 3'd1 == FAIL_LIMIT) begin
                    state_n = LOCKOUT;
                    fail_n  = 2'd0;
                    tens_n  = LOCK_TENS;
                    ones_n  = LOCK_ONES;
                end else begin
                    state_n = IDLE;
                    fail_n  = fail_q + 2'd1;
                end
            end
            OPEN, LOCKOUT: begin
                if (wrap) begin
                    tick_n = '0;
                    if (ones == 4'd0) begin
                        ones_n = 4'd9;
                        tens_n = tens - 4'd1;
                    end else begin
                        ones_n = ones - 4'd1;
                    end
                end else begin
                    tick_n = tick + 14'd1;
                end
                // Expiry takes priority: a coincident entry is dropped under the same clear pulse.
                if (expire) begin
                    state_n = IDLE;
                    clear_n = 1'b1;
                end else if (attempt) begin
                    clear_n = 1'b1;
                    if (state == OPEN && bus.set_mode && bcd_ok(bus.pw_16bit)) begin
                        stored_n = bus.pw_16bit;
                        state_n  = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge clk_12500hz or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            enough_d <= 1'b1;
            cap      <= '0;
            stored   <= DEFAULT_PW;
            fail_q   <= 2'd0;
            tick     <= '0;
            tens     <= 4'd0;
            ones     <= 4'd0;
            unlock_q <= 1'b0;
            alarm_q  <= 1'b0;
            enb_q    <= 1'b0;
            clear_q  <= 1'b0;
            led_q    <= 16'hFFFF;
        end else begin
            state    <= state_n;
            enough_d <= bus.enough;
            cap      <= cap_n;
            stored   <= stored_n;
            fail_q   <= fail_n;
            tick     <= tick_n;
            tens     <= tens_n;
            ones     <= ones_n;
            unlock_q <= (state_n == OPEN);
            alarm_q  <= (state_n == LOCKOUT);
            enb_q    <= timed_n;
            clear_q  <= clear_n;
            led_q    <= timed_n ? {8'hFF, tens_show, ones_n} : 16'hFFFF;
        end
    end

    assign bus.unlock      = unlock_q;
    assign bus.alarm       = alarm_q;
    assign bus.enb_count   = enb_q;
    assign bus.led_cnt16   = led_q;
    assign bus.clear_entry = clear_q;
    assign bus.fail_cnt    = fail_q;
endmodule

// File: tb/tb_pw_verify_ctrl.sv
// tb/tb_pw_verify_ctrl.sv - scoreboard bench for pw_verify_ctrl with an abstract cycle-count model
module tb_pw_verify_ctrl;
    localparam int TPS = 4;
    localparam int OSEC = 2;
    localparam int LSEC = 3;
    localparam int MAXF = 3;
    localparam int M_IDLE = 0, M_CHECK = 1, M_OPEN = 2, M_LOCK = 3;

    logic clk_12500hz = 1'b0;
    logic reset = 1'b1;
    always #5 clk_12500hz = ~clk_12500hz;

    pw_verify_if b1();
    pw_verify_if b2();

    pw_verify_ctrl #(.DEFAULT_PW(16'h1234), .MAX_FAIL(MAXF), .OPEN_SEC(OSEC),
                     .LOCKOUT_SEC(LSEC), .TICKS_PER_SEC(TPS))
        dut (.clk_12500hz(clk_12500hz), .reset(reset), .bus(b1));

    pw_verify_ctrl #(.DEFAULT_PW(16'h1234), .MAX_FAIL(3), .OPEN_SEC(2),
                     .LOCKOUT_SEC(12), .TICKS_PER_SEC(2))
        dut2 (.clk_12500hz(clk_12500hz), .reset(reset), .bus(b2));

    int n_tests = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic        unlock;
        logic        alarm;
        logic [1:0]  fail;
        logic [15:0] led;
    } resp_t;
    resp_t sb[$];

    // Reference model: remaining time is a plain cycle count; the display is derived by division.
    int          m_mode = M_IDLE;
    int          m_remain = 0;
    int          m_fail = 0;
    logic [15:0] m_stored = 16'h1234;
    logic [15:0] m_cap = 16'h0000;
    logic        m_prev = 1'b1;
    logic        m_clear = 1'b0;
    logic        m_unlock = 1'b0, m_alarm = 1'b0, m_enb = 1'b0;
    logic [15:0] m_led = 16'hFFFF;

    function automatic logic digits_ok(input logic [15:0] v);
        for (int i = 0; i < 4; i++)
            if (((v >> (4 * i)) & 16'hF) > 16'd9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [15:0] show(input int secs);
        logic [3:0] t, o;
        t = 4'(secs / 10);
        o = 4'(secs % 10);
        return {8'hFF, (secs < 10) ? 4'hF : t, o};
    endfunction

    initial begin
        logic att;
        forever begin
            @(posedge clk_12500hz or posedge reset);
            if (reset) begin
                m_mode = M_IDLE; m_remain = 0; m_fail = 0; m_stored = 16'h1234;
                m_cap = 16'h0000; m_prev = 1'b1; m_clear = 1'b0;
                sb.delete();
            end else begin
                att = b1.enough && !m_prev;
                m_prev = b1.enough;
                m_clear = 1'b0;
                if (m_mode == M_IDLE) begin
                    if (att) begin m_cap = b1.pw_16bit; m_mode = M_CHECK; end
                end else if (m_mode == M_CHECK) begin
                    m_clear = 1'b1;
                    if (m_cap == m_stored && digits_ok(m_cap)) begin
                        m_mode = M_OPEN; m_remain = OSEC * TPS; m_fail = 0;
                    end else if (m_fail + 1 == MAXF) begin
                        m_mode = M_LOCK; m_remain = LSEC * TPS; m_fail = 0;
                    end else begin
                        m_mode = M_IDLE; m_fail = m_fail + 1;
                    end
                end else begin
                    m_remain = m_remain - 1;
                    if (m_remain == 0) begin
                        m_mode = M_IDLE; m_clear = 1'b1;
                    end else if (att) begin
                        m_clear = 1'b1;
                        if (m_mode == M_OPEN && b1.set_mode && digits_ok(b1.pw_16bit)) begin
                            m_stored = b1.pw_16bit; m_mode = M_IDLE;
                        end
                    end
                end
            end
            m_unlock = (m_mode == M_OPEN);
            m_alarm  = (m_mode == M_LOCK);
            m_enb    = m_unlock || m_alarm;
            m_led    = m_enb ? show((m_remain + TPS - 1) / TPS) : 16'hFFFF;
            if (m_clear) sb.push_back('{m_unlock, m_alarm, 2'(m_fail), m_led});
        end
    end

    // Monitor: every cycle against the model, and each clear_entry pulse against the scoreboard.
    initial begin
        resp_t r;
        forever begin
            @(negedge clk_12500hz);
            check("cycle_outputs",
                  {b1.unlock, b1.alarm, b1.enb_count, b1.clear_entry, b1.fail_cnt, b1.led_cnt16},
                  {m_unlock, m_alarm, m_enb, m_clear, 2'(m_fail), m_led});
            if (b1.clear_entry) begin
                check("sb_has_entry", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    r = sb.pop_front();
                    check("sb_response", {b1.unlock, b1.alarm, b1.fail_cnt, b1.led_cnt16}, r);
                end
            end
        end
    end

    task automatic enter(input logic [15:0] code, input logic sm);
        @(negedge clk_12500hz);
        b1.pw_16bit = code; b1.set_mode = sm; b1.enough = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_12500hz);
            if (b1.clear_entry) break;
        end
        b1.enough = 1'b0; b1.set_mode = 1'b0;
        @(negedge clk_12500hz);
    endtask

    task automatic wait_idle();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_12500hz);
            if (!b1.unlock && !b1.alarm) begin seen = 1'b1; break; end
        end
        check("wait_idle", 32'(seen), 1);
    endtask

    task automatic pulse_reset();
        @(negedge clk_12500hz);
        #3 reset = 1'b1;
        #1 check("async_reset", {b1.unlock, b1.alarm, b1.enb_count, b1.clear_entry, b1.fail_cnt, b1.led_cnt16},
                 {4'b0000, 2'b00, 16'hFFFF});
        @(negedge clk_12500hz);
        reset = 1'b0;
    endtask

    initial begin
        int hi;
        logic [15:0] code;
        logic [15:0] exp_led;
        b1.enough = 1'b0; b1.pw_16bit = 16'h0000; b1.set_mode = 1'b0;
        b2.enough = 1'b0; b2.pw_16bit = 16'h0000; b2.set_mode = 1'b0;
        repeat (3) @(negedge clk_12500hz);
        check("reset_values", {b1.unlock, b1.alarm, b1.enb_count, b1.clear_entry, b1.fail_cnt, b1.led_cnt16},
              {4'b0000, 2'b00, 16'hFFFF});
        reset = 1'b0;

        // Correct code: unlock two edges after the attempt edge, eight cycles open.
        @(negedge clk_12500hz);
        b1.pw_16bit = 16'h1234; b1.enough = 1'b1;
        @(negedge clk_12500hz);
        check("s1_check_cycle_unlock", 32'(b1.unlock), 0);
        @(negedge clk_12500hz);
        check("s1_unlock", 32'(b1.unlock), 1);
        check("s1_led_first", 32'(b1.led_cnt16), 32'hFFF2);
        check("s1_clear_entry", 32'(b1.clear_entry), 1);
        b1.enough = 1'b0;
        hi = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_12500hz);
            if (!b1.unlock) break;
            hi++;
            if (hi == 5) check("s1_led_second", 32'(b1.led_cnt16), 32'hFFF1);
        end
        check("s1_open_len", 32'(hi), 8);
        check("s1_expiry_clear", 32'(b1.clear_entry), 1);

        // Three mismatches lead to lockout.
        enter(16'h1111, 1'b0); check("s2_fail1", 32'(b1.fail_cnt), 1);
        enter(16'h1111, 1'b0); check("s2_fail2", 32'(b1.fail_cnt), 2);
        enter(16'h1111, 1'b0);
        check("s2_alarm", 32'(b1.alarm), 1);
        check("s2_fail_cleared", 32'(b1.fail_cnt), 0);
        check("s2_led", 32'(b1.led_cnt16), 32'hFFF3);
        enter(16'h1234, 1'b0);
        check("s2_no_unlock_in_lockout", 32'(b1.unlock), 0);
        wait_idle();

        // Password change while open.
        enter(16'h1234, 1'b0); check("s3_unlock", 32'(b1.unlock), 1);
        enter(16'h5678, 1'b1); check("s3_relock", 32'(b1.unlock), 0);
        enter(16'h1234, 1'b0); check("s3_old_rejected", 32'(b1.unlock), 0);
        enter(16'h5678, 1'b0); check("s3_new_accepted", 32'(b1.unlock), 1);
        pulse_reset();
        enter(16'h1234, 1'b0); check("s5_default_restored", 32'(b1.unlock), 1);
        wait_idle();

        // Blank / non-BCD digits.
        enter(16'h12FF, 1'b0); check("s4_blank_rejected", 32'(b1.unlock), 0);
        enter(16'h1234, 1'b0); check("s4_unlock", 32'(b1.unlock), 1);
        enter(16'hA234, 1'b1); check("s4_bad_set_ignored", 32'(b1.unlock), 1);
        wait_idle();
        enter(16'h1234, 1'b0); check("s4_pw_unchanged", 32'(b1.unlock), 1);
        wait_idle();

        // Level already high at reset release is not an attempt.
        @(negedge clk_12500hz);
        reset = 1'b1; b1.enough = 1'b1; b1.pw_16bit = 16'h1234;
        @(negedge clk_12500hz);
        reset = 1'b0;
        repeat (4) @(negedge clk_12500hz);
        check("s5_held_enough_unlock", 32'(b1.unlock), 0);
        b1.enough = 1'b0;
        @(negedge clk_12500hz);

        // Randomized traffic.
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 3))
                0: code = m_stored;
                1: code = 16'h1234;
                2: code = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                           4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                default: code = 16'($urandom);
            endcase
            enter(code, $urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 12)) @(negedge clk_12500hz);
            if ($urandom_range(0, 24) == 0) pulse_reset();
        end
        wait_idle();

        // Two-digit countdown on the second instance: 12 s lockout, 2 ticks per second.
        for (int a = 0; a < 3; a++) begin
            @(negedge clk_12500hz);
            b2.pw_16bit = 16'h1111; b2.enough = 1'b1;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk_12500hz);
                if (b2.clear_entry) break;
            end
            b2.enough = 1'b0;
            if (a < 2) @(negedge clk_12500hz);
        end
        check("s6_alarm", 32'(b2.alarm), 1);
        for (int s = 12; s >= 1; s--) begin
            exp_led = {8'hFF, (s >= 10) ? 4'(s / 10) : 4'hF, 4'(s % 10)};
            for (int c = 0; c < 2; c++) begin
                check("s6_led_seq", 32'(b2.led_cnt16), 32'(exp_led));
                @(negedge clk_12500hz);
            end
        end
        check("s6_led_done", 32'(b2.led_cnt16), 32'hFFFF);
        check("s6_alarm_done", 32'(b2.alarm), 0);

        repeat (2) @(negedge clk_12500hz);
        check("sb_drained", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
